// File: rtl/led_matrix_pwm.sv
// led_matrix_pwm: bus-mapped multiplexed LED matrix driver with per-LED PWM
// brightness. Scans ROWS anodes x COLS cathode sinks, one row at a time.
// Optional build macro LED_MATRIX_DOUBLE_BUFFER_EN: bus brightness accesses
// target a back buffer that is copied to the displayed front buffer on a
// swap request (at a frame boundary, or immediately while disabled).
module led_matrix_pwm #(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int PWM_BITS = 4,
  parameter int PRESCALE = 256
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [31:0]         address_in,
  input  logic                sel_in,
  input  logic                read_in,
  output logic [31:0]         read_value_out,
  input  logic [3:0]          write_mask_in,
  input  logic [31:0]         write_value_in,
  output logic                ready_out,
  output logic [ROWS-1:0]     aled,
  output logic [COLS-1:0]     kled_en
);

  localparam int LEDS = ROWS * COLS;
  localparam int PS_W = $clog2(PRESCALE);
  localparam logic [PS_W-1:0]     PS_LAST  = PS_W'(PRESCALE - 1);
  localparam logic [PWM_BITS-1:0] PWM_LAST = '1;
  localparam logic [3:0]          ROW_LAST = 4'(ROWS - 1);

  // Bus decode: only word offsets [7:2] matter; BRIGHT window starts at word 16
  logic [5:0] word;
  logic [5:0] bright_idx;
  logic       wr_en;
  logic       ctrl_wr;
  logic       bright_hit;

  assign word       = address_in[7:2];
  assign wr_en      = sel_in && (write_mask_in != 4'b0);
  assign ctrl_wr    = wr_en && (word == 6'd0);
  assign bright_idx = word - 6'd16;
  assign bright_hit = (word >= 6'd16) && ({26'b0, bright_idx} < 32'(LEDS));
  assign ready_out  = sel_in;

  // Bits of the bus that carry no meaning for this block
  logic unused_bits;
  assign unused_bits = ^{read_in, address_in[31:8], address_in[1:0], write_value_in};

  logic                enable_reg;
  logic [PS_W-1:0]     prescale_reg;
  logic [PWM_BITS-1:0] pwm_reg;
  logic [3:0]          row_reg;
  logic [15:0]         frame_reg;
  logic                presc_last;
  logic                pwm_last;
  logic                row_last;
  logic                frame_wrap;

  assign presc_last = (prescale_reg == PS_LAST);
  assign pwm_last   = (pwm_reg == PWM_LAST);
  assign row_last   = (row_reg == ROW_LAST);
  assign frame_wrap = enable_reg && presc_last && pwm_last && row_last;

  // Bus-visible brightness storage; 64 slots so any 6-bit index is legal,
  // slots at or above LEDS are never written and stay zero
  logic [PWM_BITS-1:0] bus_mem [64];
  logic                swap_pending;

  // Enable bit and the prescaler/pwm/row/frame scan counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable_reg   <= 1'b0;
      prescale_reg <= '0;
      pwm_reg      <= '0;
      row_reg      <= '0;
      frame_reg    <= '0;
    end else begin
      if (ctrl_wr) enable_reg <= write_value_in[0];
      if (!enable_reg) begin
        prescale_reg <= '0;
        pwm_reg      <= '0;
        row_reg      <= '0;
        frame_reg    <= '0;
      end else if (!presc_last) begin
        prescale_reg <= prescale_reg + 1'b1;
      end else begin
        prescale_reg <= '0;
        if (!pwm_last) begin
          pwm_reg <= pwm_reg + 1'b1;
        end else begin
          pwm_reg <= '0;
          if (row_last) begin
            row_reg   <= '0;
            frame_reg <= frame_reg + 16'd1;
          end else begin
            row_reg <= row_reg + 4'd1;
          end
        end
      end
    end
  end

  // Brightness writes from the bus; out-of-range indices are dropped
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 64; i++) bus_mem[i] <= '0;
    end else if (wr_en && bright_hit) begin
      bus_mem[bright_idx] <= write_value_in[PWM_BITS-1:0];
    end
  end

`ifdef LED_MATRIX_DOUBLE_BUFFER_EN
  logic [PWM_BITS-1:0] front_mem [64];
  logic                swap_pending_reg;
  logic                swap_now;

  // A pending swap fires at the frame boundary, or at once when not scanning
  assign swap_now     = swap_pending_reg && (!enable_reg || frame_wrap);
  assign swap_pending = swap_pending_reg;

  // Front buffer copy and swap request bookkeeping; a new request wins over clearing
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 64; i++) front_mem[i] <= '0;
      swap_pending_reg <= 1'b0;
    end else begin
      if (swap_now) begin
        for (int i = 0; i < 64; i++) front_mem[i] <= bus_mem[i];
      end
      swap_pending_reg <= (swap_pending_reg && !swap_now) || (ctrl_wr && write_value_in[1]);
    end
  end
`else
  assign swap_pending = 1'b0;
`endif

  // Next-cycle drive: one-hot row, column sinks on while brightness exceeds pwm
  logic [ROWS-1:0] aled_next;
  logic [COLS-1:0] kled_next;

  genvar gi;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_row
      assign aled_next[gi] = enable_reg && (row_reg == 4'(gi));
    end
    for (gi = 0; gi < COLS; gi++) begin : g_col
      logic [5:0] led_idx;
      assign led_idx = 6'(32'(row_reg) * COLS + gi);
`ifdef LED_MATRIX_DOUBLE_BUFFER_EN
      assign kled_next[gi] = enable_reg && (front_mem[led_idx] > pwm_reg);
`else
      assign kled_next[gi] = enable_reg && (bus_mem[led_idx] > pwm_reg);
`endif
    end
  endgenerate

  // Registered pin drive; row and column change together on one edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      aled    <= '0;
      kled_en <= '0;
    end else begin
      aled    <= aled_next;
      kled_en <= kled_next;
    end
  end

  // Combinational read mux; drives zero when not selected so the bus can OR
  always_comb begin
    read_value_out = '0;
    if (sel_in) begin
      if (word == 6'd0) begin
        read_value_out = {30'b0, swap_pending, enable_reg};
      end else if (word == 6'd1) begin
        read_value_out = {frame_reg, 8'(pwm_reg), 4'b0, row_reg};
      end else if (bright_hit) begin
        read_value_out = 32'(bus_mem[bright_idx]);
      end
    end
  end

endmodule
